// File: rtl/dtc_inverse_search.sv
// Sequential inverse of a dtc_* classifier: sweeps candidate inputs through an external
// classifier and returns the first input whose code matches. Optional macro: DTC_INV_COUNT_EN.
module dtc_inverse_search #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int CNT_W = IN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_code,
    input  logic [OUT_W-1:0] req_mask,
    input  logic [IN_W-1:0]  req_start,
    output logic [IN_W-1:0]  dt_inp,
    input  logic [OUT_W-1:0] dt_outp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic [IN_W-1:0]  rsp_inp,
    output logic [CNT_W-1:0] rsp_count
);

    typedef enum logic [1:0] {StIdle, StSweep, StResp} state_e;

    localparam logic [IN_W-1:0] CandOne = IN_W'(1);
    localparam logic [IN_W-1:0] CandMax = {IN_W{1'b1}};

    state_e           state_q, state_d;
    logic [OUT_W-1:0] code_q, code_d;
    logic [OUT_W-1:0] mask_q, mask_d;
    logic [IN_W-1:0]  cand_q, cand_d;
    logic [IN_W-1:0]  inp_q, inp_d;
    logic             found_q, found_d;
    logic             match;
    logic             last;

    // dt_outp is only meaningful in SWEEP; match is never consulted elsewhere
    assign match = ((dt_outp ^ code_q) & mask_q) == '0;
    assign last  = (cand_q == CandMax);

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign dt_inp    = (state_q == StSweep) ? cand_q : '0;
    assign rsp_found = found_q;
    assign rsp_inp   = inp_q;

`ifdef DTC_INV_COUNT_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;

    assign rsp_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    assign rsp_count = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            code_q  <= '0;
            mask_q  <= '0;
            cand_q  <= '0;
            inp_q   <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mask_q  <= mask_d;
            cand_q  <= cand_d;
            inp_q   <= inp_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        mask_d  = mask_q;
        cand_d  = cand_q;
        inp_d   = inp_q;
        found_d = found_q;
`ifdef DTC_INV_COUNT_EN
        count_d = count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    code_d  = req_code;
                    mask_d  = req_mask;
                    cand_d  = req_start;
                    inp_d   = '0;
                    found_d = 1'b0;
`ifdef DTC_INV_COUNT_EN
                    count_d = '0;
`endif
                    state_d = StSweep;
                end
            end
            StSweep: begin
`ifdef DTC_INV_COUNT_EN
                // Full sweep to the top of the space; only the earliest match is kept
                if (match) begin
                    if (!found_q) begin
                        found_d = 1'b1;
                        inp_d   = cand_q;
                    end
                    count_d = count_q + CntOne;
                end
                if (last) begin
                    state_d = StResp;
                end else begin
                    cand_d = cand_q + CandOne;
                end
`else
                if (match) begin
                    found_d = 1'b1;
                    inp_d   = cand_q;
                    state_d = StResp;
                end else if (last) begin
                    found_d = 1'b0;
                    inp_d   = '0;
                    state_d = StResp;
                end else begin
                    cand_d = cand_q + CandOne;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_dtc_inverse_search.sv
// Self-checking bench for dtc_inverse_search with a selectable stub classifier and a
// reference-model scoreboard.
module tb_dtc_inverse_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_code = '0;
    logic [7:0] req_mask = '0;
    logic [7:0] req_start = '0;
    logic [7:0] dt_inp;
    logic [7:0] dt_outp;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_found;
    logic [7:0] rsp_inp;
    logic [8:0] rsp_count;

    int checks = 0;
    int errors = 0;
    int stub_mode = 0;

    typedef struct {
        logic       found;
        logic [7:0] inp;
        logic [8:0] count;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dtc_inverse_search #(
        .IN_W (8),
        .OUT_W(8),
        .CNT_W(9)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_code (req_code),
        .req_mask (req_mask),
        .req_start(req_start),
        .dt_inp   (dt_inp),
        .dt_outp  (dt_outp),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_found(rsp_found),
        .rsp_inp  (rsp_inp),
        .rsp_count(rsp_count)
    );

    function automatic logic [7:0] stub(int mode, logic [7:0] x);
        case (mode)
            0:       return x + 8'd1;
            1:       return 8'h01;
            default: return {4'h0, x[3:0]};
        endcase
    endfunction

    // Classifier output is undefined while the searcher idles
    always_comb dt_outp = req_ready ? 8'hxx : stub(stub_mode, dt_inp);

    function automatic exp_t model(logic [7:0] code, logic [7:0] mask, logic [7:0] start);
        exp_t       e;
        logic [7:0] cb;
        logic [7:0] o;
        e.found = 1'b0;
        e.inp   = '0;
        e.count = '0;
        e.lat   = 0;
        for (int c = int'(start); c < 256; c++) begin
            cb = c[7:0];
            o  = stub(stub_mode, cb);
            e.lat++;
            if (((o ^ code) & mask) == 8'h00) begin
                if (!e.found) begin
                    e.found = 1'b1;
                    e.inp   = cb;
                end
`ifdef DTC_INV_COUNT_EN
                e.count = e.count + 9'd1;
`else
                break;
`endif
            end
        end
        return e;
    endfunction

    task automatic send_req(input logic [7:0] code, input logic [7:0] mask,
                            input logic [7:0] start);
        int n = 0;
        req_valid = 1'b1;
        req_code  = code;
        req_mask  = mask;
        req_start = start;
        while (!req_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout got req_ready=%0b want 1", req_ready);
        end
        sb.push_back(model(code, mask, start));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Called just after the accepting edge; lat counts edges until rsp_valid is seen
    task automatic wait_rsp(output logic f, output logic [7:0] i, output logic [8:0] c,
                            output int lat);
        int n = 0;
        while (!rsp_valid && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout got rsp_valid=%0b want 1", rsp_valid);
        end
        f   = rsp_found;
        i   = rsp_inp;
        c   = rsp_count;
        lat = n;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_found} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got %b want 100", {req_ready, rsp_valid, rsp_found});
        end
        checks++;
        if ({rsp_inp, rsp_count, dt_inp} !== 25'h0) begin
            errors++;
            $display("FAIL reset_data got inp=%h cnt=%0d dt_inp=%h want 0 0 0",
                     rsp_inp, rsp_count, dt_inp);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_match();
        logic f; logic [7:0] i; logic [8:0] c; int lat; exp_t e;
        stub_mode = 0;
        send_req(8'h10, 8'hFF, 8'h00);
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || i !== 8'h0F) begin
            errors++;
            $display("FAIL basic_result got f=%0b inp=%h want f=%0b inp=%h", f, i, e.found, e.inp);
        end
        checks++;
        if (c !== e.count || lat !== e.lat) begin
            errors++;
            $display("FAIL basic_cnt_lat got cnt=%0d lat=%0d want cnt=%0d lat=%0d",
                     c, lat, e.count, e.lat);
        end
        handshake();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release got valid=%0b ready=%0b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_top_and_nomatch();
        logic f; logic [7:0] i; logic [8:0] c; int lat; exp_t e;
        stub_mode = 0;
        send_req(8'h00, 8'hFF, 8'h80);
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || c !== e.count || lat !== e.lat) begin
            errors++;
            $display("FAIL top_match got f=%0b inp=%h cnt=%0d lat=%0d want %0b %h %0d %0d",
                     f, i, c, lat, e.found, e.inp, e.count, e.lat);
        end
        handshake();
        stub_mode = 1;
        send_req(8'h00, 8'hFF, 8'h00);
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || c !== e.count || lat !== e.lat) begin
            errors++;
            $display("FAIL nomatch got f=%0b inp=%h cnt=%0d lat=%0d want %0b %h %0d %0d",
                     f, i, c, lat, e.found, e.inp, e.count, e.lat);
        end
        handshake();
        stub_mode = 0;
        send_req(8'h00, 8'hFF, 8'hFF);
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || lat !== e.lat || lat !== 1) begin
            errors++;
            $display("FAIL single_cand got f=%0b inp=%h lat=%0d want %0b %h %0d",
                     f, i, lat, e.found, e.inp, e.lat);
        end
        handshake();
    endtask

    task automatic test_mask_zero_hold();
        logic f; logic [7:0] i; logic [8:0] c; int lat; exp_t e;
        stub_mode = 0;
        send_req(8'hA5, 8'h00, 8'h37);
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || c !== e.count || lat !== e.lat) begin
            errors++;
            $display("FAIL mask0 got f=%0b inp=%h cnt=%0d lat=%0d want %0b %h %0d %0d",
                     f, i, c, lat, e.found, e.inp, e.count, e.lat);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_found !== e.found ||
                rsp_inp !== e.inp || rsp_count !== e.count) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got v=%0b r=%0b f=%0b inp=%h cnt=%0d", k,
                         rsp_valid, req_ready, rsp_found, rsp_inp, rsp_count);
            end
        end
        handshake();
    endtask

    task automatic test_count();
        logic f; logic [7:0] i; logic [8:0] c; int lat; exp_t e;
        stub_mode = 2;
        send_req(8'h05, 8'h0F, 8'h00);
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || i !== 8'h05) begin
            errors++;
            $display("FAIL count_first got f=%0b inp=%h want %0b %h", f, i, e.found, e.inp);
        end
        checks++;
        if (c !== e.count || lat !== e.lat) begin
            errors++;
            $display("FAIL count_value got cnt=%0d lat=%0d want cnt=%0d lat=%0d",
                     c, lat, e.count, e.lat);
        end
        handshake();
    endtask

    task automatic test_reset_mid_sweep();
        logic f; logic [7:0] i; logic [8:0] c; int lat; exp_t e;
        stub_mode = 1;
        send_req(8'h00, 8'hFF, 8'h00);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dt_inp !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got v=%0b r=%0b dt_inp=%h want 0 1 00",
                     rsp_valid, req_ready, dt_inp);
        end
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stub_mode = 0;
        send_req(8'h40, 8'hFF, 8'h20);
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || c !== e.count || lat !== e.lat) begin
            errors++;
            $display("FAIL post_reset got f=%0b inp=%h cnt=%0d lat=%0d want %0b %h %0d %0d",
                     f, i, c, lat, e.found, e.inp, e.count, e.lat);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic f; logic [7:0] i; logic [8:0] c; int lat; exp_t e;
        int n = 0;
        int early = 0;
        stub_mode = 0;
        send_req(8'h20, 8'hFF, 8'h10);
        // Second request held (with different fields) while the first is in flight
        req_valid = 1'b1;
        req_code  = 8'h10;
        req_mask  = 8'hFF;
        req_start = 8'h00;
        while (!rsp_valid && n < 600) begin
            if (req_ready) early++;
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (rsp_found !== e.found || rsp_inp !== e.inp || rsp_count !== e.count ||
            n !== e.lat) begin
            errors++;
            $display("FAIL b2b_first got f=%0b inp=%h cnt=%0d lat=%0d want %0b %h %0d %0d",
                     rsp_found, rsp_inp, rsp_count, n, e.found, e.inp, e.count, e.lat);
        end
        checks++;
        if (early != 0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_blocked got early_ready=%0d ready=%0b want 0 0", early, req_ready);
        end
        handshake();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dt_inp !== 8'h00) begin
            errors++;
            $display("FAIL b2b_idle got r=%0b v=%0b dt_inp=%h want 1 0 00",
                     req_ready, rsp_valid, dt_inp);
        end
        sb.push_back(model(8'h10, 8'hFF, 8'h00));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got ready=%0b want 0", req_ready);
        end
        wait_rsp(f, i, c, lat);
        e = sb.pop_front();
        checks++;
        if (f !== e.found || i !== e.inp || c !== e.count || lat !== e.lat) begin
            errors++;
            $display("FAIL b2b_second got f=%0b inp=%h cnt=%0d lat=%0d want %0b %h %0d %0d",
                     f, i, c, lat, e.found, e.inp, e.count, e.lat);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_top_and_nomatch();
        test_mask_zero_hold();
        test_count();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
